// File: rtl/aes_inv_sbox_seq.sv
// Iterative AES inverse S-box: inverse affine, then y^254 by square-and-multiply in 7 cycles.
// Define AES_INV_SBOX_OVERLAP_EN to accept the next byte on the same edge as the output handshake.
module aes_inv_sbox_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_byte
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] y_r;
   logic [7:0] r_r;
   logic [7:0] out_byte_r;
   logic [2:0] cnt_r;
   logic       accept_s;
   logic       release_s;
   logic [7:0] y_in_s;
   logic [7:0] sq_s;
   logic [7:0] step_s;

   function automatic logic [7:0] inv_affine(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         p  = p ^ (b[i] ? aa : 8'h00);
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Squaring is linear: spread bits to even positions, then fold back modulo 0x11B.
   function automatic logic [7:0] gf_sq(input logic [7:0] a);
      logic [14:0] t;
      t = 15'h0000;
      for (int i = 0; i < 8; i++) begin
         t[2*i] = a[i];
      end
      for (int i = 14; i >= 8; i--) begin
         t[i -: 9] = t[i -: 9] ^ (t[i] ? 9'h11B : 9'h000);
      end
      return t[7:0];
   endfunction

   assign y_in_s    = inv_affine(in_byte);
   assign sq_s      = gf_sq(r_r);
   assign step_s    = gf_mul(sq_s, y_r);
   assign accept_s  = in_valid && in_ready;
   assign release_s = out_valid && out_ready;
   assign out_byte  = out_byte_r;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == 3'd6) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = CALC;
            end
         end
         DONE: begin
            if (release_s && accept_s) begin
               state_nxt_s = CALC;
            end else if (release_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_r)
         IDLE: in_ready = 1'b1;
         CALC: in_ready = 1'b0;
         DONE: begin
            out_valid = 1'b1;
`ifdef AES_INV_SBOX_OVERLAP_EN
            in_ready  = out_ready;
`else
            in_ready  = 1'b0;
`endif
         end
         default: in_ready = 1'b0;
      endcase
   end

   // Exponent chain datapath; the last step is a bare square giving y^254
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_r        <= 8'h00;
         r_r        <= 8'h00;
         cnt_r      <= 3'd0;
         out_byte_r <= 8'h00;
      end else if (accept_s) begin
         y_r   <= y_in_s;
         r_r   <= y_in_s;
         cnt_r <= 3'd0;
      end else if (state_r == CALC) begin
         cnt_r <= cnt_r + 3'd1;
         if (cnt_r == 3'd6) begin
            r_r        <= sq_s;
            out_byte_r <= sq_s;
         end else begin
            r_r <= step_s;
         end
      end
   end

endmodule

// File: tb/tb_aes_inv_sbox_seq.sv
// Directed and round-trip bench for aes_inv_sbox_seq; handshake spacing follows AES_INV_SBOX_OVERLAP_EN.
module tb_aes_inv_sbox_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_byte;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [7:0] sb [256];

   aes_inv_sbox_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_byte   (in_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_byte  (out_byte)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box by brute-force inverse plus forward affine
   function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
         if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Present a byte, wait for accept, return edges from accept until out_valid
   task automatic send(input logic [7:0] b, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = b;
      #1;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      check_val("accept_wait", 32'(w < 50), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   logic [7:0] dir_in  [5] = '{8'h63, 8'h7c, 8'h16, 8'h00, 8'hed};
   logic [7:0] dir_exp [5] = '{8'h00, 8'h01, 8'hff, 8'h52, 8'h53};

   initial begin
      int lat;
      int nacc;
      int nout;
      int ho [2];
      logic [7:0] ob [2];
      logic pend;
      int idx_in;
      int idx_out;
      logic acc;

      for (int i = 0; i < 256; i++) sb[i] = fwd_sbox(8'(i));

      rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
      #2;
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_out_byte", out_byte, 8'h00);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("post_rst_in_ready", in_ready, 1);

      // Directed vectors with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(dir_in[i], lat);
         check_val($sformatf("dir_lat_%02h", dir_in[i]), lat, 7);
         check_val($sformatf("dir_out_%02h", dir_in[i]), out_byte, dir_exp[i]);
         @(posedge clk);
         #1;
         check_val("dir_hs_drop", out_valid, 0);
         check_val("dir_hold", out_byte, dir_exp[i]);
      end

      // Backpressure: DONE holds while inputs wiggle
      out_ready = 1'b0;
      send(8'h7c, lat);
      check_val("bp_lat", lat, 7);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         in_byte  = 8'($urandom);
         #1;
         check_val("bp_valid", out_valid, 1);
         check_val("bp_byte", out_byte, 8'h01);
         check_val("bp_in_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_val("bp_release_valid", out_valid, 0);
      check_val("bp_release_idle", in_ready, 1);
      check_val("bp_release_hold", out_byte, 8'h01);

      // Reset in the middle of CALC
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = 8'h16;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("calc_busy", in_ready, 0);
      rst = 1'b1;
      #1;
      check_val("midrst_valid", out_valid, 0);
      check_val("midrst_byte", out_byte, 8'h00);
      check_val("midrst_ready", in_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      send(8'h63, lat);
      check_val("midrst_lat", lat, 7);
      check_val("midrst_out", out_byte, 8'h00);
      @(posedge clk);
      #1;

      // Back-to-back stream with both sides always ready
      nacc = 0; nout = 0; pend = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_byte   = 8'h7c;
      for (int c = 0; c < 60 && nout < 2; c++) begin
         #1;
         if (out_valid && out_ready) begin
            ho[nout] = cyc;
            ob[nout] = out_byte;
            nout++;
         end
         pend = in_valid && in_ready;
         @(negedge clk);
         if (pend) begin
            nacc++;
            if (nacc == 1) in_byte = 8'h16;
            else in_valid = 1'b0;
         end
      end
      check_val("stream_count", nout, 2);
      check_val("stream_out0", ob[0], 8'h01);
      check_val("stream_out1", ob[1], 8'hff);
`ifdef AES_INV_SBOX_OVERLAP_EN
      check_val("stream_gap", ho[1] - ho[0], 8);
`else
      check_val("stream_gap", ho[1] - ho[0], 9);
`endif
      in_valid = 1'b0;
      repeat (12) @(negedge clk);

      // Exhaustive round trip with random stalls on both sides
      idx_in = 0; idx_out = 0; acc = 1'b0;
      for (int c = 0; c < 30000 && idx_out < 256; c++) begin
         @(negedge clk);
         if (acc) in_valid = 1'b0;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!in_valid && idx_in < 256 && $urandom_range(0, 2) != 0) begin
            in_valid = 1'b1;
            in_byte  = sb[idx_in];
         end
         #1;
         if (out_valid && out_ready) begin
            check_val($sformatf("roundtrip_%02h", idx_out[7:0]), out_byte, idx_out[7:0]);
            idx_out++;
         end
         acc = in_valid && in_ready;
         if (acc) idx_in++;
      end
      check_val("roundtrip_count", idx_out, 256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_sbox_seq.md
# aes_inv_sbox_seq

Iterative AES inverse S-box (InvSubBytes for one byte) for the decrypt datapath, the counterpart of the forward combinational S-box. It applies the inverse affine transform, then computes the GF(2^8) multiplicative inverse by square-and-multiply over 7 clock cycles. This trades a 256-entry table for one GF multiplier plus a small FSM. Valid/ready handshakes on both sides allow a decrypt controller to stream bytes through it.

## Interface
- No parameters; widths fixed at 8 bits.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  block can accept a byte.
- `in_byte`  in  8  S-box-domain byte to invert.
- `out_valid`  out  1  `out_byte` holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_byte`  out  8  InvSbox(`in_byte`).

## Operation
- Inverse affine transform: `y = rotl(a,1) ^ rotl(a,3) ^ rotl(a,6) ^ 8'h05`, where `a` is `in_byte`.
- Inversion: `r = y^254` in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1 (`9'h11B`). The inverse of 0 is defined as 0; the exponent chain yields this naturally, so no special case is needed.
- Exponent chain: start with `r = y`.
  - Steps 0..5: `r <= sq(r)·y`. Exponents go 3, 7, 15, 31, 63, 127.
  - Step 6: `r <= sq(r)`, giving exponent 254.
  - `sq` is the linear GF squaring. The multiplier is one combinational GF(2^8) multiply (shift-xor, 8 partial products).
- FSM states: `IDLE`, `CALC`, `DONE`.
  - `IDLE`: `in_ready=1`. On `in_valid && in_ready`: `y <= invaffine(in_byte)`, `r <= invaffine(in_byte)`, `cnt <= 0`, go to `CALC`.
  - `CALC`: `in_ready=0`, `out_valid=0`. Each edge performs one step and `cnt++` (3-bit). When `cnt==6` the step is a square only; on that edge `out_byte <= sq(r)` and the FSM goes to `DONE`.
  - `DONE`: `out_valid=1`. On `out_valid && out_ready`, go to `IDLE`. `in_ready` follows the Configuration section.
- `out_byte` is a dedicated register, loaded only on `CALC`→`DONE`. It holds its value afterwards, including after the output handshake.
- `in_byte` is sampled only on the accept edge. Changes to it during `CALC` or `DONE` have no effect.
- `out_ready` has no effect outside `DONE`.

## Timing
- Reset values: state `IDLE`, `in_ready=1`, `out_valid=0`, `out_byte=8'h00`, `cnt=0`, `y=0`, `r=0`.
- Latency: accept on edge E; `out_valid` rises after edge E+7 and stays high until the output handshake.
- Throughput without the macro: one byte per 9 cycles when `out_ready` is held high (accept E, output handshake E+8, next accept E+9).
- Backpressure: with `out_ready=0`, `DONE` holds indefinitely. `out_byte` and `out_valid` stay stable, and no input is accepted.
- Reset asserted mid-`CALC` or in `DONE`: all registers return to reset values immediately and asynchronously. The in-flight byte is discarded. After deassertion, the first edge with `in_valid=1` is accepted.
- `in_ready` and `out_valid` are decoded from state only. There is no combinational path from `in_valid` or `out_ready` to them, except `in_ready` when `AES_INV_SBOX_OVERLAP_EN` is defined.

## Configuration
- Macro: `AES_INV_SBOX_OVERLAP_EN`.
- Defined:
  - In `DONE`, `in_ready = out_ready`.
  - On an edge with both handshakes, the result is consumed and the new byte is loaded; the FSM goes directly to `CALC`.
  - Throughput becomes one byte per 8 cycles.
  - `out_valid` falls for 7 cycles and `out_byte` holds the old value until the next result loads.
- Undefined: `in_ready=0` in `DONE`. Every result passes through `IDLE` before the next accept.

## Test plan
- Reset, then send `8'h63` with `out_ready=1`: `out_valid` rises exactly 7 edges after accept, `out_byte=8'h00`. Then send `8'h7c` → `8'h01`, `8'h16` → `8'hff`, `8'h00` → `8'h52`, `8'hed` → `8'h53`.
- Exhaustive round trip: for all a in 0..255, feed forward `sbox(a)` → `out_byte==a`. Run once with random `in_valid`/`out_ready` stalls and check the 256 results in order.
- Backpressure: send `8'h7c` with `out_ready=0` for 20 cycles, and toggle `in_valid`/`in_byte` meanwhile. Required: `out_valid=1`, `out_byte=8'h01` stable, `in_ready=0` throughout. Raise `out_ready` → one handshake, back to `IDLE`.
- Reset mid-`CALC`: assert `rst` 3 cycles after accepting `8'h16`. Required: `out_valid=0`, `out_byte=8'h00` immediately. After release, `8'h63` → `8'h00` with normal latency.
- Overlap (macro defined): hold `in_valid=1` and `out_ready=1` and stream `8'h7c`, `8'h16`. Required: outputs `8'h01`, `8'hff` with handshakes 8 cycles apart. Same stream with macro undefined: handshakes 9 cycles apart.
